// File: rtl/st_demux_pkg.sv
// st_demux_pkg: shared channel enumeration and counter width for the st_demux block
package st_demux_pkg;
    typedef enum logic {CH_0 = 1'b0, CH_1 = 1'b1} ch_e;
    localparam int CNT_W = 32;
endpackage

// File: rtl/st_demux_if.sv
// st_demux_if: stream bundle for st_demux_2; master = upstream/downstream side, slave = demux.
// Carries the input beat (data/channel/valid/ready), both output streams, both fill levels and both beat counters.
interface st_demux_if
    import st_demux_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16
);
    localparam int AWIDTH = $clog2(DEPTH);
    logic [DWIDTH-1:0] in_data;
    logic              in_channel;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] out_data_0;
    logic              out_valid_0;
    logic              out_ready_0;
    logic [DWIDTH-1:0] out_data_1;
    logic              out_valid_1;
    logic              out_ready_1;
    logic [AWIDTH:0]   fill_0;
    logic [AWIDTH:0]   fill_1;
    logic [CNT_W-1:0]  beats_0;
    logic [CNT_W-1:0]  beats_1;
    modport master (
        output in_data, in_channel, in_valid, out_ready_0, out_ready_1,
        input  in_ready, out_data_0, out_valid_0, out_data_1, out_valid_1,
               fill_0, fill_1, beats_0, beats_1
    );
    modport slave (
        input  in_data, in_channel, in_valid, out_ready_0, out_ready_1,
        output in_ready, out_data_0, out_valid_0, out_data_1, out_valid_1,
               fill_0, fill_1, beats_0, beats_1
    );
endinterface

// File: rtl/st_demux_fifo.sv
// st_demux_fifo: first-word-fall-through FIFO, async active-high reset.
// Ports: clk, rst, push/wdata (write), pop/rdata (head read), full, empty, fill (0..DEPTH).
module st_demux_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   fill
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign full    = fill == (AWIDTH + 1)'(DEPTH);
    assign empty   = fill == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (AWIDTH + 1)'(do_push) - (AWIDTH + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/st_demux_2.sv
// st_demux_2: 1-to-2 stream demux steering each beat by channel bit into a per-output FWFT FIFO.
// Ports: clk, rst (async, active-high), bus (st_demux_if.slave).
// Optional macro ST_DEMUX_CNT_EN enables the 32-bit accepted-beat counters beats_0/beats_1 (tied to 0 otherwise).
module st_demux_2
    import st_demux_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst,
    st_demux_if.slave   bus
);
    logic full_0, full_1, empty_0, empty_1, accept, push_0, push_1;
    // Ready follows only the addressed FIFO, so a stalled beat blocks the whole input (order preserved).
    assign bus.in_ready    = ch_e'(bus.in_channel) == CH_1 ? !full_1 : !full_0;
    assign accept          = bus.in_valid && bus.in_ready;
    assign push_0          = accept && ch_e'(bus.in_channel) == CH_0;
    assign push_1          = accept && ch_e'(bus.in_channel) == CH_1;
    assign bus.out_valid_0 = !empty_0;
    assign bus.out_valid_1 = !empty_1;
    st_demux_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_fifo_0 (
        .clk(clk), .rst(rst), .push(push_0), .wdata(bus.in_data),
        .pop(bus.out_ready_0), .rdata(bus.out_data_0),
        .full(full_0), .empty(empty_0), .fill(bus.fill_0)
    );
    st_demux_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) u_fifo_1 (
        .clk(clk), .rst(rst), .push(push_1), .wdata(bus.in_data),
        .pop(bus.out_ready_1), .rdata(bus.out_data_1),
        .full(full_1), .empty(empty_1), .fill(bus.fill_1)
    );
`ifdef ST_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_0, cnt_1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (push_0) cnt_0 <= cnt_0 + 1'b1;
            if (push_1) cnt_1 <= cnt_1 + 1'b1;
        end
    end
    assign bus.beats_0 = cnt_0;
    assign bus.beats_1 = cnt_1;
`else
    assign bus.beats_0 = '0;
    assign bus.beats_1 = '0;
`endif
endmodule

// File: tb/tb_st_demux_2.sv
// tb_st_demux_2: randomized and directed checks of st_demux_2 against a queue-based reference model
module tb_st_demux_2;
    localparam int DW = 8;
    localparam int DP = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int cnt0 = 0;
    int cnt1 = 0;
    always #5 clk = ~clk;
    st_demux_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();
    st_demux_2 #(.DWIDTH(DW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] cnt_exp(input int n);
`ifdef ST_DEMUX_CNT_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction
    // Compare DUT against the queues, clock once, then advance the model by the rules of the demux.
    task automatic tick();
        logic rdy, acc, p0, p1;
        #1;
        rdy = bus.in_channel ? (q1.size() != DP) : (q0.size() != DP);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("out_valid_0", 32'(bus.out_valid_0), 32'(q0.size() != 0));
        check("out_valid_1", 32'(bus.out_valid_1), 32'(q1.size() != 0));
        if (q0.size() != 0) check("out_data_0", 32'(bus.out_data_0), 32'(q0[0]));
        if (q1.size() != 0) check("out_data_1", 32'(bus.out_data_1), 32'(q1[0]));
        check("fill_0", 32'(bus.fill_0), 32'(q0.size()));
        check("fill_1", 32'(bus.fill_1), 32'(q1.size()));
        check("beats_0", bus.beats_0, cnt_exp(cnt0));
        check("beats_1", bus.beats_1, cnt_exp(cnt1));
        acc = bus.in_valid && rdy;
        p0 = q0.size() != 0 && bus.out_ready_0;
        p1 = q1.size() != 0 && bus.out_ready_1;
        @(posedge clk);
        #1;
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc && !bus.in_channel) begin q0.push_back(bus.in_data); cnt0++; end
        if (acc && bus.in_channel) begin q1.push_back(bus.in_data); cnt1++; end
    endtask
    task automatic drive(input logic v, input logic ch, input logic [DW-1:0] d, input logic r0, input logic r1);
        bus.in_valid = v;
        bus.in_channel = ch;
        bus.in_data = d;
        bus.out_ready_0 = r0;
        bus.out_ready_1 = r1;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_fill_0", 32'(bus.fill_0), 0);
        check("rst_fill_1", 32'(bus.fill_1), 0);
        check("rst_valid_0", 32'(bus.out_valid_0), 0);
        check("rst_valid_1", 32'(bus.out_valid_1), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_beats_0", bus.beats_0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Alternating channels, both outputs always ready: one-cycle latency, no stall.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1'(i % 2 == 0), 8'(i), 1, 1);
            tick();
            check("alt_in_ready", 32'(bus.in_ready), 1);
            check("alt_latency", 32'(i % 2 == 0 ? bus.out_data_1 : bus.out_data_0), 32'(i));
        end
        drive(0, 0, 0, 1, 1);
        tick();
        tick();
        // Fill FIFO 0 to DEPTH, present the 17th beat, release one pop, then the 17th beat goes in.
        for (int i = 0; i < DP; i++) begin
            drive(1, 0, 8'(8'h40 + i), 0, 0);
            tick();
        end
        drive(1, 0, 8'h5f, 0, 0);
        #1;
        check("full_fill_0", 32'(bus.fill_0), DP);
        check("full_in_ready", 32'(bus.in_ready), 0);
        tick();
        drive(1, 0, 8'h5f, 1, 0);
        tick();
        check("full_pop_no_push", 32'(bus.fill_0), DP - 1);
        drive(1, 0, 8'h5f, 0, 0);
        tick();
        check("full_17th_in", 32'(bus.fill_0), DP);
        // Head-of-line blocking: a ch0 beat stalls while FIFO 0 is full, so ch1 never gets through.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h77, 0, 0);
            tick();
            check("hol_valid_1", 32'(bus.out_valid_1), 0);
        end
        drive(1, 0, 8'h77, 1, 0);
        tick();
        drive(1, 1, 8'h88, 0, 0);
        tick();
        check("hol_after_pop", 32'(bus.out_valid_1), 1);
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < DP + 2; i++) tick();
        // FIFO 1 with 5 entries: push and pop in the same cycle keeps fill at 5.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 8'(8'h90 + i), 0, 0);
            tick();
        end
        drive(1, 1, 8'h95, 0, 1);
        tick();
        check("pushpop_fill_1", 32'(bus.fill_1), 5);
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick();
        // Random traffic: pointer wrap, backpressure, simultaneous push/pop on both sides.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        tick();
        // Reset mid-stream with buffered beats, asserted between edges.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'(i % 2), 8'(8'hc0 + i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid_0", 32'(bus.out_valid_0), 0);
        check("mid_rst_valid_1", 32'(bus.out_valid_1), 0);
        check("mid_rst_fill_0", 32'(bus.fill_0), 0);
        check("mid_rst_fill_1", 32'(bus.fill_1), 0);
        check("mid_rst_beats_0", bus.beats_0, 0);
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 0, 8'ha5, 0, 0);
        tick();
        check("post_rst_head", 32'(bus.out_data_0), 32'h a5);
        // Counters: 10 beats to channel 0 (including 0xA5) and 3 to channel 1.
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 8'(i), 1, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'(i), 1, 1);
            tick();
        end
        drive(0, 0, 0, 1, 1);
        tick();
`ifdef ST_DEMUX_CNT_EN
        check("cnt_beats_0", bus.beats_0, 10);
        check("cnt_beats_1", bus.beats_1, 3);
`else
        check("cnt_beats_0", bus.beats_0, 0);
        check("cnt_beats_1", bus.beats_1, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/st_demux_2.md
# st_demux_2

Single-clock 1-to-2 Avalon-ST demultiplexer. It takes one input stream and steers each beat, by its channel bit, into one of two per-output buffers. It is the fan-out counterpart of the 2-input merge stage and is used where a shared stream (e.g. packet metadata) is split back onto two parallel engines. Each output has independent backpressure through its own FIFO.

## Interface
- DWIDTH, 8: data width in bits.
- DEPTH, 16: per-output FIFO depth in entries. Power of two, at least 2.
- AWIDTH, $clog2(DEPTH): FIFO pointer width.

- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- in_data, in, DWIDTH: input beat.
- in_channel, in, 1: destination select, 0 → out 0, 1 → out 1.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input beat accepted when in_valid && in_ready.
- out_data_0, out, DWIDTH: output 0 data.
- out_valid_0, out, 1: output 0 valid.
- out_ready_0, in, 1: output 0 ready.
- out_data_1, out, DWIDTH: output 1 data.
- out_valid_1, out, 1: output 1 valid.
- out_ready_1, in, 1: output 1 ready.
- fill_0, out, AWIDTH+1: occupancy of FIFO 0.
- fill_1, out, AWIDTH+1: occupancy of FIFO 1.
- beats_0, out, 32: accepted-beat counter, output 0 (see Configuration).
- beats_1, out, 32: accepted-beat counter, output 1 (see Configuration).

## Operation
- Steering: an accepted beat is written only to FIFO[in_channel]. No beat is duplicated or dropped.
- in_ready = (fill[in_channel] != DEPTH). in_ready depends combinationally on in_channel only, never on in_valid.
- Head-of-line blocking is intentional. A beat aimed at a full FIFO stalls the input even if the other FIFO has room, which preserves input order.
- Full FIFO: no push in that cycle, even if a pop occurs in the same cycle. There is no pass-through when full.
- Each FIFO is first-word-fall-through. out_valid_k = (fill_k != 0), and out_data_k is the head entry.
- Pop on out_valid_k && out_ready_k.
- Simultaneous push and pop on the same non-full, non-empty FIFO: fill is unchanged and both pointers advance.
- Simultaneous push and pop on an empty FIFO: only the push takes effect. The pop is impossible because out_valid is 0.
- Pointers are AWIDTH bits and wrap modulo DEPTH. fill is AWIDTH+1 bits and ranges 0..DEPTH.
- Per-output FIFO order equals input acceptance order for that channel.
- Reset values: fill_k=0, out_valid_k=0, beats_k=0, read/write pointers 0. in_ready is 1 during reset deassertion (both FIFOs empty). out_data_k is don't-care.
- Reset mid-operation: all buffered beats are discarded immediately, asynchronously. Nothing reaches the outputs after rst rises.

## Timing
- Latency: a beat accepted at rising edge N appears with out_valid_k=1 after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Throughput: one beat per cycle into either output while the target FIFO is not full. Each output drains one beat per cycle.
- fill_k updates on the edge where push or pop occurs.
- out_data_k is read combinationally from storage (LUT-RAM/registers). No registered read stage.

## Configuration
- ST_DEMUX_CNT_EN defined:
  - beats_k increments by 1 on every accepted beat with in_channel==k.
  - 32-bit counters, wrapping from 0xFFFFFFFF to 0.
  - Cleared only by rst.
- Not defined: beats_0 and beats_1 are tied to 0 and no counter logic is instantiated.

## Structure
- Package st_demux_pkg holds the channel enumeration (CH_0=1'b0, CH_1=1'b1) and the counter width constant CNT_W=32.
- One sub-module, st_demux_fifo (DWIDTH, DEPTH): a synchronous FWFT FIFO with push/pop/full/empty/fill. It is instantiated twice.
- The top level contains only steering, ready generation and the optional counters.

## Test plan
- Alternating channels: 8 beats, data 0x01..0x08, channel 0,1,0,1… with both out_ready=1 → out 0 receives 01,03,05,07 and out 1 receives 02,04,06,08. Each beat appears one cycle after acceptance, and in_ready stays 1.
- Fill to full: DEPTH=16, out_ready_0=0, 17 beats on channel 0 → fill_0=16. in_ready=0 while the 17th beat is presented. out_ready_0=1 for one cycle, then the 17th beat is accepted on the following edge.
- Head-of-line blocking: FIFO 0 full, beat on channel 0 followed by a beat on channel 1 → neither is accepted and out_valid_1 stays 0 until FIFO 0 pops.
- Simultaneous push/pop: FIFO 1 holds 5 entries and a push and pop occur in the same cycle → fill_1 stays 5. Output order is preserved across 40 beats spanning pointer wrap.
- Reset mid-stream: 6 beats buffered, assert rst asynchronously between edges → out_valid_0/1 go 0 immediately, fill=0 and beats=0. After release, the first new beat comes out first.
- Counters (ST_DEMUX_CNT_EN defined): 10 beats to channel 0 and 3 to channel 1 → beats_0=10, beats_1=3. With the macro undefined, both read 0.
